// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and filter lane helper for the 3x3 convolution engine.
package conv_pkg;
    localparam int DATA_W   = 8;
    localparam int ACC_W    = 20;
    localparam int OUT_DIM  = 28;
    localparam int ROW_WAIT = 2;
    localparam int TAPS     = 9;
    localparam int PROD_W   = 2 * DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_ROW_ADV,
        ST_DRAIN
    } state_e;

    // Coefficient k = row*3 + col sits in byte lane k of the packed filter word.
    function automatic logic [DATA_W-1:0] coef_lane(input logic [TAPS*DATA_W-1:0] filt,
                                                    input int unsigned k);
        return filt[k*DATA_W +: DATA_W];
    endfunction
endpackage

// File: rtl/conv3x3_mac.sv
// Two-stage unsigned 3x3 multiply-accumulate: nine registered products, then a registered adder tree.
module conv3x3_mac
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [3*DATA_W-1:0]    line1,
    input  logic [3*DATA_W-1:0]    line2,
    input  logic [3*DATA_W-1:0]    line3,
    input  logic [TAPS*DATA_W-1:0] filter_in,
    output logic                   out_valid,
    output logic [ACC_W-1:0]       result,
    output logic                   pipe_busy
);
    logic [DATA_W-1:0] pix [TAPS];
    logic [PROD_W-1:0] prod_p1 [TAPS];
    logic              vld_p1;
    logic              vld_p2;
    logic [ACC_W-1:0]  sum_d;
    logic [ACC_W-1:0]  sum_p2;

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            pix[c]     = line1[c*DATA_W +: DATA_W];
            pix[3 + c] = line2[c*DATA_W +: DATA_W];
            pix[6 + c] = line3[c*DATA_W +: DATA_W];
        end
    end

    // Stage 1: products
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_p1[k] <= PROD_W'(pix[k]) * PROD_W'(coef_lane(filter_in, k));
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_d = sum_d + ACC_W'(prod_p1[k]);
        end
    end

    // Stage 2: adder tree; result holds between write-backs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            sum_p2 <= '0;
        end else begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sum_p2 <= sum_d;
            end
        end
    end

    assign out_valid = vld_p2;
    assign result    = sum_p2;
    assign pipe_busy = vld_p1 | vld_p2;
endmodule

// File: rtl/conv3x3_engine.sv
// Walks a 3x3 window over a 30x30 image held in external storage, producing a 28x28 raster of sums.
module conv3x3_engine
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    input  logic [3*DATA_W-1:0]    line1,
    input  logic [3*DATA_W-1:0]    line2,
    input  logic [3*DATA_W-1:0]    line3,
    input  logic [TAPS*DATA_W-1:0] filter_in,
    output logic                   shift_en,
    output logic                   wb_en,
    output logic [ACC_W-1:0]       result,
    output logic                   busy,
    output logic                   done,
    output logic [4:0]             col_idx,
    output logic [4:0]             row_idx
);
    localparam logic [4:0] LAST      = 5'(OUT_DIM - 1);
    localparam logic [1:0] WAIT_LAST = 2'(ROW_WAIT - 1);

    state_e     state_q, state_d;
    logic [4:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [1:0] wait_q, wait_d;
    logic       cap_vld;
    logic       pipe_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wait_q  <= wait_d;
        end
    end

    // Stall freezes every transition; the MAC pipeline keeps draining independently.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        wait_d   = wait_q;
        shift_en = 1'b0;
        cap_vld  = 1'b0;
        done     = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    cap_vld = 1'b1;
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    shift_en = 1'b1;
                    if (col_q != LAST) begin
                        col_d   = col_q + 5'd1;
                        state_d = ST_CAPTURE;
                    end else if (row_q != LAST) begin
                        col_d   = '0;
                        row_d   = row_q + 5'd1;
                        wait_d  = '0;
                        state_d = ST_ROW_ADV;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_ROW_ADV: begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    if (!pipe_busy) begin
                        done    = 1'b1;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy    = (state_q != ST_IDLE) && !done;
    assign col_idx = col_q;
    assign row_idx = row_q;

    conv3x3_mac u_mac (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (cap_vld),
        .line1     (line1),
        .line2     (line2),
        .line3     (line3),
        .filter_in (filter_in),
        .out_valid (wb_en),
        .result    (result),
        .pipe_busy (pipe_busy)
    );
endmodule

// File: tb/tb_conv3x3_engine.sv
// Bench for conv3x3_engine: models the window storage and checks every sum against a direct 2-D convolution.
module tb_conv3x3_engine;
    localparam int N    = 28;
    localparam int IMG  = 30;
    localparam int NPIX = 784;
    localparam int RW   = 2;

    logic        clk = 1'b0;
    logic        rst, start, stall;
    logic [23:0] line1, line2, line3;
    logic [71:0] filter_in;
    logic        shift_en, wb_en, busy, done;
    logic [19:0] result;
    logic [4:0]  col_idx, row_idx;

    always #5 clk = ~clk;

    conv3x3_engine dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .line1(line1), .line2(line2), .line3(line3), .filter_in(filter_in),
        .shift_en(shift_en), .wb_en(wb_en), .result(result), .busy(busy),
        .done(done), .col_idx(col_idx), .row_idx(row_idx)
    );

    logic [7:0]  img [IMG][IMG];
    logic [7:0]  filt [9];
    int unsigned exp_res [NPIX];
    logic        ovr = 1'b0;
    logic [23:0] ovr_l2 = '0;

    int total = 0, bad = 0;

    // Monitor state
    logic        mon_clr = 1'b1;
    int          nshift, nwb, ndone, mon_err, cyc, c_busy0;
    int          shift_cyc [NPIX+8];
    int          wb_cyc [NPIX+8];
    logic [19:0] first_res, first_got;
    int unsigned first_exp;
    int          first_idx;
    logic [4:0]  row_after;
    logic        row_rec;

    // Storage model: window position follows the count of shift pulses, raster order.
    always_comb begin
        line1 = '0;
        line2 = '0;
        line3 = '0;
        if (ovr) begin
            line2 = ovr_l2;
        end else if (nshift < NPIX) begin
            for (int j = 0; j < 3; j++) begin
                line1[8*j +: 8] = img[nshift/N][nshift%N + j];
                line2[8*j +: 8] = img[nshift/N + 1][nshift%N + j];
                line3[8*j +: 8] = img[nshift/N + 2][nshift%N + j];
            end
        end
    end

    always_comb begin
        filter_in = '0;
        for (int k = 0; k < 9; k++) filter_in[8*k +: 8] = filt[k];
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            nshift <= 0; nwb <= 0; ndone <= 0; mon_err <= 0; cyc <= 0; c_busy0 <= -1;
            first_res <= '0; first_got <= '0; first_exp <= 0; first_idx <= -1;
            row_after <= '0; row_rec <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (busy && c_busy0 < 0) c_busy0 <= cyc;
            if (shift_en) begin
                if (nshift < NPIX + 8) shift_cyc[nshift] <= cyc;
                nshift <= nshift + 1;
            end
            if (wb_en) begin
                if (nwb < NPIX + 8) wb_cyc[nwb] <= cyc;
                if (nwb == 0) first_res <= result;
                if (nwb >= NPIX) begin
                    mon_err <= mon_err + 1;
                end else if (result !== exp_res[nwb][19:0]) begin
                    if (mon_err == 0) begin
                        first_got <= result; first_exp <= exp_res[nwb]; first_idx <= nwb;
                    end
                    mon_err <= mon_err + 1;
                end
                nwb <= nwb + 1;
            end
            if (done) ndone <= ndone + 1;
            if (nshift == N && !shift_en && !row_rec) begin
                row_after <= row_idx;
                row_rec   <= 1'b1;
            end
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic compute_exp();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int unsigned s;
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s = s + img[r+i][c+j] * filt[i*3+j];
                exp_res[r*N + c] = s;
            end
        end
    endtask

    task automatic fill_const(input logic [7:0] p, input logic [7:0] f);
        for (int r = 0; r < IMG; r++) for (int c = 0; c < IMG; c++) img[r][c] = p;
        for (int k = 0; k < 9; k++) filt[k] = f;
        compute_exp();
    endtask

    task automatic fill_random();
        for (int r = 0; r < IMG; r++) for (int c = 0; c < IMG; c++) img[r][c] = 8'($urandom);
        for (int k = 0; k < 9; k++) filt[k] = 8'($urandom);
        compute_exp();
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if (ndone > 0) begin ok = 1'b1; break; end
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic wait_count(input bit use_wb, input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if ((use_wb ? nwb : nshift) >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        total++;
        if ({shift_en, wb_en, result, busy, done, col_idx, row_idx} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0",
                {shift_en, wb_en, result, busy, done, col_idx, row_idx});
        end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_ones();
        bit ok;
        fill_const(8'd1, 8'd1);
        clear_mon(); pulse_start(); wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL ones_timeout done=%0d want>0", ndone); end
        total++; if (nwb !== NPIX) begin bad++; $display("FAIL ones_wb got=%0d want=%0d", nwb, NPIX); end
        total++; if (mon_err !== 0) begin bad++; $display("FAIL ones_result idx=%0d got=%0d want=%0d", first_idx, first_got, first_exp); end
        total++; if (nshift !== NPIX) begin bad++; $display("FAIL ones_shift got=%0d want=%0d", nshift, NPIX); end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ones_done got=%0d want=1", ndone); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ones_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_max();
        bit ok;
        fill_const(8'd255, 8'd255);
        clear_mon(); pulse_start(); wait_done(ok);
        total++; if (nwb !== NPIX) begin bad++; $display("FAIL max_wb got=%0d want=%0d", nwb, NPIX); end
        total++; if (mon_err !== 0) begin bad++; $display("FAIL max_result idx=%0d got=%0d want=%0d", first_idx, first_got, first_exp); end
        total++; if (first_res !== 20'h8EE09) begin bad++; $display("FAIL max_first got=%h want=8ee09", first_res); end
    endtask

    task automatic test_identity();
        bit ok;
        ovr = 1'b1; ovr_l2 = 24'h00AB00;
        for (int k = 0; k < 9; k++) filt[k] = (k == 4) ? 8'd1 : 8'd0;
        for (int p = 0; p < NPIX; p++) exp_res[p] = 32'hAB;
        clear_mon(); pulse_start(); wait_done(ok);
        ovr = 1'b0;
        total++; if (mon_err !== 0) begin bad++; $display("FAIL ident_result idx=%0d got=%h want=%h", first_idx, first_got, first_exp); end
        total++; if (nwb !== NPIX) begin bad++; $display("FAIL ident_wb got=%0d want=%0d", nwb, NPIX); end
        total++; if (wb_cyc[0] - c_busy0 !== 2) begin bad++; $display("FAIL ident_latency got=%0d want=2", wb_cyc[0] - c_busy0); end
    endtask

    task automatic test_row_boundary();
        bit ok;
        fill_random();
        clear_mon(); pulse_start(); wait_done(ok);
        total++; if (mon_err !== 0) begin bad++; $display("FAIL rand_result idx=%0d got=%0d want=%0d", first_idx, first_got, first_exp); end
        total++; if (nwb !== NPIX) begin bad++; $display("FAIL rand_wb got=%0d want=%0d", nwb, NPIX); end
        total++; if (shift_cyc[1] - shift_cyc[0] !== 2) begin bad++; $display("FAIL pixel_period got=%0d want=2", shift_cyc[1] - shift_cyc[0]); end
        total++; if (shift_cyc[N] - shift_cyc[N-1] !== 2 + RW) begin bad++; $display("FAIL row_gap got=%0d want=%0d", shift_cyc[N] - shift_cyc[N-1], 2 + RW); end
        total++; if (row_after !== 5'd1) begin bad++; $display("FAIL row_idx_adv got=%0d want=1", row_after); end
    endtask

    task automatic test_stall();
        bit ok, ok2;
        fill_random();
        clear_mon(); pulse_start();
        wait_count(1'b0, 5, ok);
        @(posedge clk); #1;
        @(posedge clk); #1 stall = 1'b1;
        repeat (5) @(posedge clk);
        #1 stall = 1'b0;
        wait_done(ok2);
        total++; if (!(ok && ok2)) begin bad++; $display("FAIL stall_timeout shifts=%0d done=%0d want 784/1", nshift, ndone); end
        total++; if (shift_cyc[5] - c_busy0 !== 16) begin bad++; $display("FAIL stall_shift_delay got=%0d want=16", shift_cyc[5] - c_busy0); end
        total++; if (wb_cyc[5] - c_busy0 !== 12) begin bad++; $display("FAIL stall_wb_sched got=%0d want=12", wb_cyc[5] - c_busy0); end
        total++; if (nshift !== NPIX) begin bad++; $display("FAIL stall_shift_total got=%0d want=%0d", nshift, NPIX); end
        total++; if (mon_err !== 0 || nwb !== NPIX) begin bad++; $display("FAIL stall_results err=%0d wb=%0d want 0/%0d", mon_err, nwb, NPIX); end
    endtask

    task automatic test_reset_mid();
        bit ok, ok2;
        int snap_s, snap_w;
        fill_random();
        clear_mon(); pulse_start();
        wait_count(1'b1, 100, ok);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        total++;
        if ({shift_en, wb_en, result, busy, done, col_idx, row_idx} !== '0) begin
            bad++; $display("FAIL midreset_outputs got=%h want=0",
                {shift_en, wb_en, result, busy, done, col_idx, row_idx});
        end
        snap_s = nshift; snap_w = nwb;
        repeat (4) @(negedge clk);
        #1;
        total++; if (nshift !== snap_s || nwb !== snap_w) begin bad++; $display("FAIL midreset_strobes got=%0d/%0d want=%0d/%0d", nshift, nwb, snap_s, snap_w); end
        @(posedge clk); #1 rst = 1'b1;
        clear_mon(); pulse_start();
        wait_count(1'b0, 50, ok2);
        pulse_start();
        wait_done(ok);
        total++; if (!(ok && ok2)) begin bad++; $display("FAIL rerun_timeout done=%0d want>0", ndone); end
        total++; if (nwb !== NPIX || nshift !== NPIX) begin bad++; $display("FAIL rerun_counts got=%0d/%0d want=%0d", nwb, nshift, NPIX); end
        total++; if (mon_err !== 0) begin bad++; $display("FAIL rerun_result idx=%0d got=%0d want=%0d", first_idx, first_got, first_exp); end
        total++; if (ndone !== 1) begin bad++; $display("FAIL rerun_done got=%0d want=1", ndone); end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_max();
        test_identity();
        test_row_boundary();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
